// File: rtl/pipe_main_control.sv
// Pipelined RV32I main control: decodes the opcode in ID and carries the control
// bundle through ID/EX, EX/MEM and MEM/WB, with load-use stall, flush and freeze.
module pipe_main_control #(
  parameter int REG_ADDR_W = 5,
  parameter int ALUOP_W    = 3,
  parameter bit JUMP_EN    = 1'b1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_valid,
  input  logic [6:0]            i_OPCode,
  input  logic [REG_ADDR_W-1:0] i_rs1,
  input  logic [REG_ADDR_W-1:0] i_rs2,
  input  logic [REG_ADDR_W-1:0] i_rd,
  input  logic                  i_flush,
  input  logic                  i_stall_ext,
  output logic                  o_stall,
  output logic [ALUOP_W-1:0]    o_ex_ALUOp,
  output logic                  o_ex_ALUSrc1,
  output logic                  o_ex_ALUSrc2,
  output logic                  o_ex_Branch,
  output logic                  o_ex_Jump,
  output logic                  o_ex_illegal,
  output logic                  o_mem_MemRead,
  output logic                  o_mem_MemWrite,
  output logic                  o_wb_RegWrite,
  output logic                  o_wb_MemToReg,
  output logic [REG_ADDR_W-1:0] o_wb_rd
);

  typedef enum logic [6:0] {
    OP_R     = 7'b0110011,
    OP_I     = 7'b0010011,
    OP_LOAD  = 7'b0000011,
    OP_STORE = 7'b0100011,
    OP_BR    = 7'b1100011,
    OP_LUI   = 7'b0110111,
    OP_AUIPC = 7'b0010111,
    OP_JAL   = 7'b1101111,
    OP_JALR  = 7'b1100111
  } opcode_e;

  typedef struct packed {
    logic [ALUOP_W-1:0]    alu_op;
    logic                  src1;
    logic                  src2;
    logic                  branch;
    logic                  jump;
    logic                  illegal;
    logic                  mem_read;
    logic                  mem_write;
    logic                  reg_write;
    logic                  mem_to_reg;
    logic [REG_ADDR_W-1:0] rd;
  } id_ex_t;

  typedef struct packed {
    logic                  mem_read;
    logic                  mem_write;
    logic                  reg_write;
    logic                  mem_to_reg;
    logic [REG_ADDR_W-1:0] rd;
  } ex_mem_t;

  typedef struct packed {
    logic                  reg_write;
    logic                  mem_to_reg;
    logic [REG_ADDR_W-1:0] rd;
  } mem_wb_t;

  id_ex_t  dec;
  id_ex_t  id_ex;
  ex_mem_t ex_mem;
  ex_mem_t ex_mem_nxt;
  mem_wb_t mem_wb;
  mem_wb_t mem_wb_nxt;
  logic    use_rs1;
  logic    use_rs2;

  // Anything not recognised (or a jump with jumps disabled) becomes a bubble flagged illegal.
  always_comb begin
    dec     = '0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    if (i_valid) begin
      case (i_OPCode)
        OP_R: begin
          dec.alu_op = ALUOP_W'(3'b010); dec.reg_write = 1'b1;
          use_rs1 = 1'b1; use_rs2 = 1'b1;
        end
        OP_I: begin
          dec.alu_op = ALUOP_W'(3'b011); dec.src2 = 1'b1; dec.reg_write = 1'b1;
          use_rs1 = 1'b1;
        end
        OP_LOAD: begin
          dec.alu_op = ALUOP_W'(3'b000); dec.src2 = 1'b1; dec.reg_write = 1'b1;
          dec.mem_read = 1'b1; dec.mem_to_reg = 1'b1;
          use_rs1 = 1'b1;
        end
        OP_STORE: begin
          dec.alu_op = ALUOP_W'(3'b000); dec.src2 = 1'b1; dec.mem_write = 1'b1;
          use_rs1 = 1'b1; use_rs2 = 1'b1;
        end
        OP_BR: begin
          dec.alu_op = ALUOP_W'(3'b001); dec.branch = 1'b1;
          use_rs1 = 1'b1; use_rs2 = 1'b1;
        end
        OP_LUI: begin
          dec.alu_op = ALUOP_W'(3'b100); dec.src2 = 1'b1; dec.reg_write = 1'b1;
        end
        OP_AUIPC: begin
          dec.alu_op = ALUOP_W'(3'b101); dec.src1 = 1'b1; dec.src2 = 1'b1;
          dec.reg_write = 1'b1;
        end
        OP_JAL: begin
          if (JUMP_EN) begin
            dec.alu_op = ALUOP_W'(3'b110); dec.src1 = 1'b1; dec.src2 = 1'b1;
            dec.reg_write = 1'b1; dec.jump = 1'b1;
          end else begin
            dec.illegal = 1'b1;
          end
        end
        OP_JALR: begin
          if (JUMP_EN) begin
            dec.alu_op = ALUOP_W'(3'b110); dec.src2 = 1'b1;
            dec.reg_write = 1'b1; dec.jump = 1'b1;
            use_rs1 = 1'b1;
          end else begin
            dec.illegal = 1'b1;
          end
        end
        default: dec.illegal = 1'b1;
      endcase
      if (!dec.illegal) begin
        dec.rd = i_rd;
      end
      dec.reg_write = dec.reg_write & (i_rd != '0);
    end
  end

  // A load in EX whose destination feeds the ID instruction must wait one cycle.
  assign o_stall = id_ex.mem_read && (id_ex.rd != '0) && i_valid &&
                   ((use_rs1 && (id_ex.rd == i_rs1)) || (use_rs2 && (id_ex.rd == i_rs2)));

  assign ex_mem_nxt = '{mem_read:   id_ex.mem_read,
                        mem_write:  id_ex.mem_write,
                        reg_write:  id_ex.reg_write,
                        mem_to_reg: id_ex.mem_to_reg,
                        rd:         id_ex.rd};

  assign mem_wb_nxt = '{reg_write:  ex_mem.reg_write,
                        mem_to_reg: ex_mem.mem_to_reg,
                        rd:         ex_mem.rd};

  // Flush beats the freeze for ID/EX only; the later stages still respect the freeze.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      id_ex  <= '0;
      ex_mem <= '0;
      mem_wb <= '0;
    end else if (i_flush) begin
      id_ex <= '0;
      if (!i_stall_ext) begin
        ex_mem <= ex_mem_nxt;
        mem_wb <= mem_wb_nxt;
      end
    end else if (!i_stall_ext) begin
      id_ex  <= o_stall ? '0 : dec;
      ex_mem <= ex_mem_nxt;
      mem_wb <= mem_wb_nxt;
    end
  end

  assign o_ex_ALUOp     = id_ex.alu_op;
  assign o_ex_ALUSrc1   = id_ex.src1;
  assign o_ex_ALUSrc2   = id_ex.src2;
  assign o_ex_Branch    = id_ex.branch;
  assign o_ex_Jump      = id_ex.jump;
  assign o_ex_illegal   = id_ex.illegal;
  assign o_mem_MemRead  = ex_mem.mem_read;
  assign o_mem_MemWrite = ex_mem.mem_write;
  assign o_wb_RegWrite  = mem_wb.reg_write;
  assign o_wb_MemToReg  = mem_wb.mem_to_reg;
  assign o_wb_rd        = mem_wb.rd;

endmodule

// File: tb/tb_pipe_main_control.sv
// Bench for pipe_main_control: two instances (jumps enabled / disabled) checked
// every cycle against a table-driven model of the control bundle moving down the pipe.
module tb_pipe_main_control;

  logic       clk = 1'b0;
  logic       rst_n, valid, flush, stall_ext;
  logic [6:0] opcode;
  logic [4:0] rs1, rs2, rd;

  logic       stall    [2];
  logic [2:0] alu_op   [2];
  logic       src1     [2];
  logic       src2     [2];
  logic       branch   [2];
  logic       jump     [2];
  logic       illegal  [2];
  logic       mem_read [2];
  logic       mem_wr   [2];
  logic       reg_wr   [2];
  logic       mem2reg  [2];
  logic [4:0] wb_rd    [2];
  logic [16:0] got     [2];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    pipe_main_control #(.REG_ADDR_W(5), .ALUOP_W(3), .JUMP_EN(g == 0)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .i_OPCode(opcode),
      .i_rs1(rs1), .i_rs2(rs2), .i_rd(rd), .i_flush(flush), .i_stall_ext(stall_ext),
      .o_stall(stall[g]), .o_ex_ALUOp(alu_op[g]), .o_ex_ALUSrc1(src1[g]),
      .o_ex_ALUSrc2(src2[g]), .o_ex_Branch(branch[g]), .o_ex_Jump(jump[g]),
      .o_ex_illegal(illegal[g]), .o_mem_MemRead(mem_read[g]), .o_mem_MemWrite(mem_wr[g]),
      .o_wb_RegWrite(reg_wr[g]), .o_wb_MemToReg(mem2reg[g]), .o_wb_rd(wb_rd[g])
    );
    assign got[g] = {alu_op[g], src1[g], src2[g], branch[g], jump[g], illegal[g],
                     mem_read[g], mem_wr[g], reg_wr[g], mem2reg[g], wb_rd[g]};
  end

  typedef struct packed {
    logic br, mr, mw, m2r, s1, s2, rw, jmp, ill;
    logic [2:0] alu;
    logic [4:0] rd;
  } bundle_t;

  // Decode table: opcode, {Br,MR,MW,M2R,S1,S2,RW,Jmp,ALUOp}, {uses rs1, uses rs2}.
  localparam logic [6:0] OP_TAB [9] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                                        7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111,
                                        7'b1100111};
  localparam logic [10:0] CTL_TAB [9] = '{11'b00000010_010, 11'b00000110_011,
                                          11'b01010110_000, 11'b00100100_000,
                                          11'b10000000_001, 11'b00000110_100,
                                          11'b00001110_101, 11'b00001111_110,
                                          11'b00000111_110};
  localparam logic [1:0] USE_TAB [9] = '{2'b11, 2'b10, 2'b10, 2'b11, 2'b11,
                                         2'b00, 2'b00, 2'b00, 2'b10};

  bundle_t m_ex [2], m_mem [2], m_wb [2];
  int      n_checks = 0;
  int      n_fail   = 0;
  logic    last_stall [2];

  function automatic int table_index(input logic [6:0] op, input int k);
    for (int i = 0; i < 9; i++)
      if (op == OP_TAB[i] && (k == 0 || i < 7)) return i;
    return -1;
  endfunction

  function automatic bundle_t model_decode(input logic v, input logic [6:0] op,
                                           input logic [4:0] d, input int k);
    bundle_t b = '0;
    int      idx;
    if (!v) return b;
    idx = table_index(op, k);
    if (idx < 0) begin
      b.ill = 1'b1;
      return b;
    end
    {b.br, b.mr, b.mw, b.m2r, b.s1, b.s2, b.rw, b.jmp, b.alu} = CTL_TAB[idx];
    b.rd = d;
    if (d == 5'd0) b.rw = 1'b0;
    return b;
  endfunction

  function automatic logic model_stall(input int k);
    int idx;
    logic [1:0] u;
    if (!valid || !m_ex[k].mr || m_ex[k].rd == 5'd0) return 1'b0;
    idx = table_index(opcode, k);
    if (idx < 0) return 1'b0;
    u = USE_TAB[idx];
    return (u[1] && m_ex[k].rd == rs1) || (u[0] && m_ex[k].rd == rs2);
  endfunction

  function automatic logic [16:0] expected(input int k);
    return {m_ex[k].alu, m_ex[k].s1, m_ex[k].s2, m_ex[k].br, m_ex[k].jmp, m_ex[k].ill,
            m_mem[k].mr, m_mem[k].mw, m_wb[k].rw, m_wb[k].m2r, m_wb[k].rd};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_ex[k] = '0; m_mem[k] = '0; m_wb[k] = '0;
    end
  endtask

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      logic s;
      s = model_stall(k);
      if (flush || !stall_ext) begin
        if (!stall_ext) begin
          m_wb[k]  = m_mem[k];
          m_mem[k] = m_ex[k];
        end
        m_ex[k] = (flush || s) ? '0 : model_decode(valid, opcode, rd, k);
      end
    end
  endtask

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_output(input string tag);
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      assert (got[k] === expected(k)) else begin
        n_fail++;
        $error("[TB] FAIL %s dut%0d outputs observed=%h expected=%h", tag, k, got[k], expected(k));
      end
    end
  endtask

  task automatic check_stall(input string tag);
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      last_stall[k] = stall[k];
      assert (stall[k] === model_stall(k)) else begin
        n_fail++;
        $error("[TB] FAIL %s dut%0d o_stall observed=%b expected=%b", tag, k, stall[k], model_stall(k));
      end
    end
  endtask

  // Called one time unit after a rising edge; leaves the bench at the same phase.
  task automatic apply_stimulus(input logic v, input logic [6:0] op, input logic [4:0] a,
                                input logic [4:0] b, input logic [4:0] d,
                                input logic fl, input logic sx, input string tag);
    valid = v; opcode = op; rs1 = a; rs2 = b; rd = d; flush = fl; stall_ext = sx;
    #2;
    check_stall(tag);
    @(posedge clk);
    model_edge();
    #1;
    check_output(tag);
  endtask

  localparam logic [6:0] R = 7'b0110011, I = 7'b0010011, LD = 7'b0000011, ST = 7'b0100011;
  localparam logic [6:0] BR = 7'b1100011, LUI = 7'b0110111, JAL = 7'b1101111;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic       cv, fl, sx, fresh;
    logic [6:0] cop;
    logic [4:0] ca, cb, cd;
    int         sel;

    rst_n = 1'b0; valid = 1'b0; opcode = '0; rs1 = '0; rs2 = '0; rd = '0;
    flush = 1'b0; stall_ext = 1'b0;
    model_reset();
    #2;
    check_output("reset");
    check_stall("reset_stall");
    @(posedge clk); #1;
    rst_n = 1'b1;

    apply_stimulus(1, R, 1, 2, 3, 0, 0, "t1_e1");
    check_val("t1_aluop", 32'(alu_op[0]), 32'b010);
    apply_stimulus(1, R, 1, 2, 3, 0, 0, "t1_e2");
    check_val("t1_mem", {30'd0, mem_read[0], mem_wr[0]}, 32'd0);
    apply_stimulus(1, R, 1, 2, 3, 0, 0, "t1_e3");
    check_val("t1_wb", {26'd0, reg_wr[0], wb_rd[0]}, {26'd0, 1'b1, 5'd3});
    repeat (3) apply_stimulus(0, 0, 0, 0, 0, 0, 0, "drain");

    apply_stimulus(1, LD, 1, 0, 5, 0, 0, "t2_load");
    apply_stimulus(1, R, 1, 5, 6, 0, 0, "t2_r_stalled");
    check_val("t2_stall_on", 32'(last_stall[0]), 32'd1);
    apply_stimulus(1, R, 1, 5, 6, 0, 0, "t2_r_issue");
    check_val("t2_stall_off", 32'(last_stall[0]), 32'd0);
    repeat (3) apply_stimulus(0, 0, 0, 0, 0, 0, 0, "t2_drain");
    apply_stimulus(1, LD, 1, 0, 0, 0, 0, "t2_load_x0");
    apply_stimulus(1, R, 1, 0, 6, 0, 0, "t2_r_x0");
    check_val("t2_no_stall_rd0", 32'(last_stall[0]), 32'd0);
    repeat (3) apply_stimulus(0, 0, 0, 0, 0, 0, 0, "drain");

    apply_stimulus(1, BR, 1, 2, 0, 0, 0, "t3_branch");
    apply_stimulus(1, I, 1, 0, 9, 1, 0, "t3_flush");
    check_val("t3_ex_zero", {24'd0, got[0][16:9]}, 32'd0);
    repeat (3) apply_stimulus(0, 0, 0, 0, 0, 0, 0, "t3_drain");

    apply_stimulus(1, R, 1, 2, 1, 0, 0, "t4_fill1");
    apply_stimulus(1, I, 1, 0, 2, 0, 0, "t4_fill2");
    apply_stimulus(1, LUI, 0, 0, 4, 0, 0, "t4_fill3");
    repeat (3) apply_stimulus(1, R, 3, 4, 7, 0, 1, "t4_freeze");
    check_val("t4_frozen_wb", 32'(wb_rd[0]), 32'd1);
    apply_stimulus(1, R, 3, 4, 7, 1, 1, "t4_flush_frozen");
    repeat (4) apply_stimulus(0, 0, 0, 0, 0, 0, 0, "t4_resume");

    apply_stimulus(1, 7'h7F, 0, 0, 8, 0, 0, "t5_illegal");
    check_val("t5_ill", 32'(illegal[0]), 32'd1);
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, "t5_after");
    check_val("t5_ill_gone", 32'(illegal[0]), 32'd0);
    apply_stimulus(1, JAL, 0, 0, 7, 0, 0, "t5_jal");
    check_val("t5_jal_en", {27'd0, jump[0], alu_op[0], src1[0]}, {27'd0, 1'b1, 3'b110, 1'b1});
    check_val("t5_jal_dis", {30'd0, illegal[1], jump[1]}, 32'b10);
    repeat (3) apply_stimulus(0, 0, 0, 0, 0, 0, 0, "t5_drain");

    apply_stimulus(1, ST, 1, 2, 0, 0, 0, "t6_store");
    apply_stimulus(1, R, 1, 2, 3, 0, 0, "t6_next");
    check_val("t6_memwrite", 32'(mem_wr[0]), 32'd1);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_output("t6_async_reset");
    @(posedge clk); #1;
    check_output("t6_held_reset");
    rst_n = 1'b1;

    fresh = 1'b1;
    cv = 0; cop = 0; ca = 0; cb = 0; cd = 0;
    for (int i = 0; i < 400; i++) begin
      if (fresh) begin
        cv  = ($urandom_range(0, 5) != 0);
        sel = $urandom_range(0, 10);
        cop = (sel < 9) ? OP_TAB[sel] : (sel == 9) ? 7'h7F : 7'($urandom);
        ca  = 5'($urandom_range(0, 3));
        cb  = 5'($urandom_range(0, 3));
        cd  = 5'($urandom_range(0, 3));
      end
      fl = ($urandom_range(0, 9) == 0);
      sx = ($urandom_range(0, 7) == 0);
      valid = cv; opcode = cop; rs1 = ca; rs2 = cb; rd = cd;
      fresh = fl || !(sx || model_stall(0));
      apply_stimulus(cv, cop, ca, cb, cd, fl, sx, "random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
